// File: rtl/apb4_sram_pkg.sv
// ----------------------------------------------------------------------------
// apb4_sram_pkg
// Shared types and constants for the APB4 SRAM slave and its wait-state
// generator: FSM state encoding, wait-mode selector, PSLVERR cause codes,
// the LFSR step function and an address-offset helper.
// ----------------------------------------------------------------------------
package apb4_sram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    typedef enum logic [1:0] {
        WAIT_NONE  = 2'd0,
        WAIT_FIXED = 2'd1,
        WAIT_RAND  = 2'd2
    } wait_mode_e;

    // Listed in checking priority: the first matching cause is recorded.
    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_UNALIGNED = 3'd1,
        ERR_RANGE     = 3'd2,
        ERR_PROT      = 3'd3,
        ERR_RD_STRB   = 3'd4
    } err_cause_e;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit at bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    // One LFSR step: shift right, feedback parity of the tapped bits enters at the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return {^(state & LFSR_TAP_MASK), state[15:1]};
    endfunction

    // Number of byte-offset bits below the word index for a given data width.
    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_wait_gen.sv
// ----------------------------------------------------------------------------
// apb_wait_gen
// Produces the wait-state count loaded by the slave at each setup phase.
// Mode 0 gives zero waits, mode 1 a fixed count, mode 2 a pseudo-random
// count MIN + (lfsr mod (MAX-MIN+1)) taken from the current LFSR value.
// The LFSR advances only when advance_i is high (one setup phase).
//
// Ports:
//   PCLK        in   clock
//   PRESETn     in   asynchronous active-low reset (LFSR returns to seed)
//   advance_i   in   setup phase accepted this cycle
//   wait_cnt_o  out  wait count for the transfer being set up (4 bits)
// ----------------------------------------------------------------------------
module apb_wait_gen
    import apb4_sram_pkg::*;
#(
    parameter int unsigned WAIT_MODE         = 0,
    parameter int unsigned FIXED_WAIT_CYC    = 2,
    parameter int unsigned MIN_RAND_WAIT_CYC = 0,
    parameter int unsigned MAX_RAND_WAIT_CYC = 4,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       advance_i,
    output logic [3:0] wait_cnt_o
);

    localparam wait_mode_e  MODE      = wait_mode_e'(WAIT_MODE[1:0]);
    localparam logic [3:0]  FIXED_W   = 4'(FIXED_WAIT_CYC);
    localparam logic [15:0] RAND_MIN  = 16'(MIN_RAND_WAIT_CYC);
    localparam logic [15:0] RAND_SPAN = 16'(MAX_RAND_WAIT_CYC - MIN_RAND_WAIT_CYC + 1);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [15:0] rand_off_s;

    // LFSR next state: step once per accepted setup phase.
    always_comb begin
        lfsr_d = lfsr_q;
        if (advance_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Wait count selection by mode; the random value uses the pre-advance LFSR.
    always_comb begin
        rand_off_s = lfsr_q % RAND_SPAN;
        wait_cnt_o = 4'd0;
        case (MODE)
            WAIT_NONE:  wait_cnt_o = 4'd0;
            WAIT_FIXED: wait_cnt_o = FIXED_W;
            WAIT_RAND:  wait_cnt_o = 4'(rand_off_s + RAND_MIN);
            default:    wait_cnt_o = 4'd0;
        endcase
    end

endmodule

// File: rtl/apb4_sram_slave.sv
// ----------------------------------------------------------------------------
// apb4_sram_slave
// APB4 memory-mapped SRAM target with byte strobes, a secure low region,
// configurable wait states and defined PSLVERR causes. Address, direction,
// data, strobes and the error verdict are frozen at the setup edge, so input
// changes during the access phase have no effect. All outputs are flops.
//
// Ports:
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   PSEL, PENABLE        APB select / access phase
//   PWRITE               1 = write
//   PADDR  [AW-1:0]      byte address
//   PWDATA [DW-1:0]      write data
//   PSTRB  [DW/8-1:0]    byte write strobes
//   PPROT  [2:0]         protection, bit 1 = non-secure
//   PRDATA [DW-1:0]      read data, held until the next completed read
//   PREADY               one-cycle transfer-complete pulse
//   PSLVERR              error, only ever high together with PREADY
// ----------------------------------------------------------------------------
module apb4_sram_slave
    import apb4_sram_pkg::*;
#(
    parameter int unsigned         ADDR_BUS_WIDTH    = 32,
    parameter int unsigned         DATA_BUS_WIDTH    = 32,
    parameter int unsigned         MEMSIZE           = 1024,
    parameter logic [DATA_BUS_WIDTH-1:0] RESET_VAL   = '0,
    parameter int unsigned         SECURE_WORDS      = 0,
    parameter int unsigned         WAIT_MODE         = 0,
    parameter int unsigned         FIXED_WAIT_CYC    = 2,
    parameter int unsigned         MIN_RAND_WAIT_CYC = 0,
    parameter int unsigned         MAX_RAND_WAIT_CYC = 4,
    parameter logic [15:0]         LFSR_SEED         = 16'hACE1
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic                        PSEL,
    input  logic                        PENABLE,
    input  logic                        PWRITE,
    input  logic [ADDR_BUS_WIDTH-1:0]   PADDR,
    input  logic [DATA_BUS_WIDTH-1:0]   PWDATA,
    input  logic [DATA_BUS_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]                  PPROT,
    output logic [DATA_BUS_WIDTH-1:0]   PRDATA,
    output logic                        PREADY,
    output logic                        PSLVERR
);

    localparam int unsigned AW   = ADDR_BUS_WIDTH;
    localparam int unsigned DW   = DATA_BUS_WIDTH;
    localparam int unsigned NB   = DW / 8;
    localparam int unsigned ALSB = addr_lsb(DW);
    localparam int unsigned IDXW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

    localparam logic [AW-1:0] ALIGN_MASK = AW'(NB - 1);
    // Index comparisons run one bit wider so MEMSIZE / SECURE_WORDS never overflow.
    localparam logic [AW:0]   MEMSIZE_X  = (AW+1)'(MEMSIZE);
    localparam logic [AW:0]   SECURE_X   = (AW+1)'(SECURE_WORDS);
    localparam logic [AW:0]   ONE_X      = (AW+1)'(1);

    apb_state_e     state_q, state_d;
    logic [AW-1:0]  word_idx_s;
    err_cause_e     err_in_s;
    logic           setup_s;
    logic [3:0]     wait_s;

    logic [IDXW-1:0] idx_q,   idx_d;
    logic            write_q, write_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]   strb_q,  strb_d;
    err_cause_e      err_q,   err_d;
    logic [3:0]      wcnt_q,  wcnt_d;
    logic            pready_q,  pready_d;
    logic            pslverr_q, pslverr_d;
    logic [DW-1:0]   prdata_q,  prdata_d;
    logic            mem_we_s;

    logic [IDXW-1:0] cur_idx_s;
    err_cause_e      cur_err_s;
    logic            cur_write_s;
    logic            prot_unused_s;

    logic [DW-1:0]   mem_q [MEMSIZE];

    assign word_idx_s    = PADDR >> ALSB;
    assign setup_s       = (state_q == ST_IDLE) && PSEL && !PENABLE;
    // Only the non-secure bit takes part in protection checking.
    assign prot_unused_s = ^{PPROT[2], PPROT[0]};

    apb_wait_gen #(
        .WAIT_MODE         (WAIT_MODE),
        .FIXED_WAIT_CYC    (FIXED_WAIT_CYC),
        .MIN_RAND_WAIT_CYC (MIN_RAND_WAIT_CYC),
        .MAX_RAND_WAIT_CYC (MAX_RAND_WAIT_CYC),
        .LFSR_SEED         (LFSR_SEED)
    ) u_wait_gen (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .advance_i  (setup_s),
        .wait_cnt_o (wait_s)
    );

    // Error verdict on the live bus, in priority order; frozen at the setup edge.
    always_comb begin
        err_in_s = ERR_NONE;
        if ((PADDR & ALIGN_MASK) != '0) begin
            err_in_s = ERR_UNALIGNED;
        end else if ({1'b0, word_idx_s} >= MEMSIZE_X) begin
            err_in_s = ERR_RANGE;
        end else if (PPROT[1] && (({1'b0, word_idx_s} + ONE_X) <= SECURE_X)) begin
            err_in_s = ERR_PROT;
        end else if (!PWRITE && (PSTRB != '0)) begin
            err_in_s = ERR_RD_STRB;
        end else begin
            err_in_s = ERR_NONE;
        end
    end

    // Transfer attributes: live bus at the setup edge (zero-wait), captured copy afterwards.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_idx_s   = word_idx_s[IDXW-1:0];
            cur_err_s   = err_in_s;
            cur_write_s = PWRITE;
        end else begin
            cur_idx_s   = idx_q;
            cur_err_s   = err_q;
            cur_write_s = write_q;
        end
    end

    // FSM next state, wait countdown and the response loaded for the PREADY cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        err_d     = err_q;
        wcnt_d    = wcnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        mem_we_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (setup_s) begin
                    state_d  = ST_ACCESS;
                    idx_d    = word_idx_s[IDXW-1:0];
                    write_d  = PWRITE;
                    wdata_d  = PWDATA;
                    strb_d   = PSTRB;
                    err_d    = err_in_s;
                    wcnt_d   = wait_s;
                    pready_d = (wait_s == 4'd0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    // Abort: leave without writing, PREADY stays low.
                    state_d = ST_IDLE;
                end else if (pready_q) begin
                    state_d  = ST_IDLE;
                    mem_we_s = write_q && (err_q == ERR_NONE);
                end else begin
                    // wcnt_q counts remaining low-PREADY cycles; 1 means this is the last.
                    wcnt_d   = wcnt_q - 4'd1;
                    pready_d = (wcnt_q == 4'd1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (pready_d) begin
            pslverr_d = (cur_err_s != ERR_NONE);
            if (cur_write_s) begin
                prdata_d = prdata_q;
            end else if (cur_err_s == ERR_NONE) begin
                prdata_d = mem_q[cur_idx_s];
            end else begin
                prdata_d = '0;
            end
        end else begin
            pslverr_d = 1'b0;
        end
    end

    // FSM, captured transfer attributes and registered outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= ERR_NONE;
            wcnt_q    <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            wcnt_q    <= wcnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Flop-based memory array with per-byte write enables on the completion edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(MEMSIZE); i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else if (mem_we_s) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (strb_q[b]) begin
                    mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb4_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_apb4_sram_slave
// Three slaves share one APB bus (separate PSEL): mode 0 (no waits), mode 1
// (3 fixed waits) and mode 2 (random waits in [1,4]). Each transfer is
// predicted from a behavioural model: word array, error rules, last read
// value and a reference LFSR for the random wait counts.
// ----------------------------------------------------------------------------
module tb_apb4_sram_slave;

    localparam logic [31:0] RV = 32'h5A5A_C3C3;

    logic        clk;
    logic        rst_n;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    int          n_checks;
    int          n_errors;
    logic [31:0] mem_m [3][1024];
    logic [31:0] last_rd [3];
    int unsigned lfsr_m;
    int          hist [5];
    int          hist_out;

    apb4_sram_slave #(.RESET_VAL(RV), .SECURE_WORDS(16), .WAIT_MODE(0)) u_m0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb4_sram_slave #(.RESET_VAL(RV), .SECURE_WORDS(16), .WAIT_MODE(1), .FIXED_WAIT_CYC(3)) u_m1 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb4_sram_slave #(.RESET_VAL(RV), .SECURE_WORDS(16), .WAIT_MODE(2),
                      .MIN_RAND_WAIT_CYC(1), .MAX_RAND_WAIT_CYC(4)) u_m2 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            last_rd[d] = 32'h0;
            for (int i = 0; i < 1024; i++) mem_m[d][i] = RV;
        end
        lfsr_m = 32'hACE1;
    endtask

    // Error rules of the slave, applied to plain integer address arithmetic.
    function automatic bit model_err(input bit wr, input logic [31:0] addr,
                                     input logic [3:0] strb, input logic [2:0] prot);
        int unsigned word;
        word = addr / 4;
        if (addr % 4 != 0) return 1'b1;
        if (word >= 1024) return 1'b1;
        if (prot[1] && word < 16) return 1'b1;
        if (!wr && strb != 4'h0) return 1'b1;
        return 1'b0;
    endfunction

    // Expected wait count for the next setup on slave d.
    function automatic int next_wait(input int d);
        int unsigned fb;
        int w;
        if (d == 0) begin
            w = 0;
        end else if (d == 1) begin
            w = 3;
        end else begin
            w = 1 + int'(lfsr_m % 4);
            fb = ((lfsr_m >> 0) ^ (lfsr_m >> 2) ^ (lfsr_m >> 3) ^ (lfsr_m >> 5)) & 1;
            lfsr_m = (lfsr_m >> 1) | (fb << 15);
        end
        return w;
    endfunction

    // One complete transfer on slave d, starting at posedge+1; ends at posedge+1.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
        bit e;
        bit done;
        int exp_w;
        int waits;
        e     = model_err(wr, addr, strb, prot);
        exp_w = next_wait(d);
        psel = 3'b000; psel[d] = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
        @(negedge clk);
        chk("setup_pready", 32'(pready[d]), 32'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        // Bus attributes change after setup; the slave must ignore them.
        pwrite = ~wr; paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom); pprot = 3'($urandom);
        done = 1'b0;
        waits = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (pready[d] === 1'b1) begin
                done  = 1'b1;
                waits = c;
            end else begin
                chk("wait_pslverr", 32'(pslverr[d]), 32'd0);
                @(posedge clk); #1;
            end
        end
        chk("pready_seen", 32'(done), 32'd1);
        if (done) begin
            chk("wait_cycles", 32'(waits), 32'(exp_w));
            chk("pslverr", 32'(pslverr[d]), 32'(e));
            if (!wr) last_rd[d] = e ? 32'h0 : mem_m[d][addr[11:2]];
            chk("prdata", prdata[d], last_rd[d]);
            if (wr && !e) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mem_m[d][addr[11:2]][b*8 +: 8] = data[b*8 +: 8];
            end
            if (d == 2) begin
                if (waits >= 1 && waits <= 4) hist[waits]++;
                else hist_out++;
            end
            @(posedge clk); #1;
        end
        psel = 3'b000;
        penable = 1'b0;
    endtask

    task automatic rand_xfer(input int d);
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        wr = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0:       addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            1:       addr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
            2:       addr = $urandom;
            default: addr = 32'($urandom_range(0, 63) * 4);
        endcase
        if (wr) strb = 4'($urandom_range(0, 15));
        else if ($urandom_range(0, 7) == 0) strb = 4'($urandom_range(1, 15));
        else strb = 4'h0;
        xfer(d, wr, addr, $urandom, strb, 3'($urandom_range(0, 7)));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        hist_out = 0;
        for (int v = 0; v < 5; v++) hist[v] = 0;
        rst_n = 1'b0;
        psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b000;
        model_reset();

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_pready", 32'(pready[d]), 32'd0);
            chk("rst_pslverr", 32'(pslverr[d]), 32'd0);
            chk("rst_prdata", prdata[d], 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Mode 0 directed: reset contents, full and partial byte writes.
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
        xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 3'b000);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
        xfer(0, 1'b1, 32'h20, 32'h55667788, 4'h0, 3'b000);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000);

        // Error causes and region boundaries.
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'h0, 3'b000);
        xfer(0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 3'b000);
        xfer(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 3'b010);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h1, 3'b000);
        xfer(0, 1'b1, 32'hFFC, 32'hA1B2C3D4, 4'hF, 3'b000);
        xfer(0, 1'b0, 32'hFFC, 32'h0, 4'h0, 3'b000);
        xfer(0, 1'b1, 32'h3C, 32'h0BADF00D, 4'hF, 3'b010);
        xfer(0, 1'b1, 32'h40, 32'h600DF00D, 4'hF, 3'b010);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b010);
        xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b000);

        // Randomized traffic on modes 0 and 1.
        for (int i = 0; i < 100; i++) rand_xfer(0);
        for (int i = 0; i < 50; i++) rand_xfer(1);

        // Abort during the wait phase of a write on mode 1.
        xfer(1, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 3'b000);
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h14; pwdata = 32'h0BADBEEF; pstrb = 4'hF; pprot = 3'b000;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 3'b000; penable = 1'b0;
        @(negedge clk);
        chk("abort_pready", 32'(pready[1]), 32'd0);
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h14, 32'h0, 4'h0, 3'b000);

        // Mode 2: random wait counts against the reference LFSR.
        for (int i = 0; i < 1000; i++) rand_xfer(2);
        chk("wait_out_of_range", 32'(hist_out), 32'd0);
        for (int v = 1; v <= 4; v++) chk("wait_value_seen", 32'(hist[v] > 0), 32'd1);

        // Reset while PREADY is high on a mode-1 write: write discarded, memory restored.
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h1C; pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b000;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_pready", 32'(pready[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_pready", 32'(pready[1]), 32'd0);
        chk("midrst_pslverr", 32'(pslverr[1]), 32'd0);
        chk("midrst_prdata", prdata[1], 32'h0);
        psel = 3'b000; penable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h1C, 32'h0, 4'h0, 3'b000);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
        for (int i = 0; i < 4; i++) rand_xfer(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
